branch_pred_ctlr: RTL and testbench

- Parametrised successor to the combinational branch controller.
- Resolves branch outcome in EX using the same `branch_in`/flag encoding and keeps the combinational `pc_src`.
- Adds a direct-mapped BTB with saturating direction counters for fetch-stage prediction, registered mispredict redirect, a multi-cycle flush FSM, and saturating performance counters.
- Sits between the fetch PC mux and the EX-stage ALU flags.

---
 rtl/branch_pred_ctlr.sv | 190 +++++++++++++++++++
 tb/tb_branch_pred_ctlr.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pred_ctlr.sv
// branch_pred_ctlr
//   Branch resolution and prediction controller. It sits between the fetch PC
//   mux and the EX-stage ALU flags.
//   - Fetch side: a direct-mapped BTB with saturating direction counters. It
//     gives a combinational prediction (pred_taken / pred_target) for fetch_pc.
//   - EX side: it resolves the branch outcome from branch_in and the ALU flags
//     (pc_src is combinational and not gated). It compares the outcome with the
//     prediction carried down the pipe, and updates the BTB and the counters.
//   - Mispredict: redirect_valid pulses for one cycle, registered, with
//     redirect_pc. flush stays high for FLUSH_CYCLES cycles. While flushing,
//     the EX stage is ignored.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     fetch_pc                   PC looked up in the BTB
//     pred_taken, pred_target    fetch-side prediction
//     ex_valid, ex_pc            EX instruction qualifier and PC
//     branch_in                  001 BEQ 010 BNE 011 BLT 100 BGE 101 JALR 110 JAL
//     zero_flag, sign_flag       ALU flags
//     ex_target                  computed branch/jump target
//     ex_pred_taken/_target      prediction carried with the EX instruction
//     pc_src                     actual taken
//     redirect_valid/_pc         registered redirect to the correct next PC
//     flush                      squash younger stages
//     branch_cnt, mispred_cnt    saturating performance counters
//   Handshake: there is no backpressure. A transaction is one cycle with
//   ex_valid=1 while the controller is in RUN. redirect_valid is a single-cycle
//   pulse that the fetch unit must accept unconditionally.
module branch_pred_ctlr #(
    parameter int XLEN         = 32,
    parameter int IDX_BITS     = 4,
    parameter int CTR_BITS     = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [2:0]       branch_in,
    input  logic             zero_flag,
    input  logic             sign_flag,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             pc_src,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = XLEN - IDX_BITS - 2;
    localparam int FCNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCNT_W-1:0]   FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT   = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_WT    = {1'b1, {(CTR_BITS-1){1'b0}}};

    typedef enum logic {RUN, FLUSH} state_t;

    state_t            state;
    logic [FCNT_W-1:0] fcnt;

    logic                btb_valid  [ENTRIES];
    logic [TAG_W-1:0]    btb_tag    [ENTRIES];
    logic [XLEN-1:0]     btb_target [ENTRIES];
    logic [CTR_BITS-1:0] btb_ctr    [ENTRIES];

    // Fetch-side lookup. It sees the contents from before the edge, so an
    // update to the same index becomes visible only in the next cycle.
    logic [IDX_BITS-1:0] f_idx;
    logic [TAG_W-1:0]    f_tag;
    logic                f_hit;
    logic                unused_fetch_lsbs;

    assign f_idx             = fetch_pc[IDX_BITS+1:2];
    assign f_tag             = fetch_pc[XLEN-1:IDX_BITS+2];
    assign f_hit             = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign pred_taken        = f_hit && btb_ctr[f_idx][CTR_BITS-1];
    assign pred_target       = f_hit ? btb_target[f_idx] : '0;
    assign unused_fetch_lsbs = ^fetch_pc[1:0];

    // Branch outcome.
    always_comb begin
        pc_src = 1'b0;
        case (branch_in)
            3'b001:         pc_src = zero_flag;
            3'b010:         pc_src = !zero_flag;
            3'b011:         pc_src = sign_flag;
            3'b100:         pc_src = !sign_flag;
            3'b101, 3'b110: pc_src = 1'b1;
            default:        pc_src = 1'b0;
        endcase
    end

    logic                is_br;
    logic                resolve;
    logic                mispredict;
    logic [XLEN-1:0]     correct_pc;
    logic [IDX_BITS-1:0] e_idx;
    logic [TAG_W-1:0]    e_tag;
    logic                e_hit;

    assign is_br      = (branch_in != 3'b000) && (branch_in != 3'b111);
    assign resolve    = ex_valid && (state == RUN);
    // A taken branch that was predicted taken but to the wrong target is also
    // a mispredict. A non-branch that was predicted taken must be undone.
    assign mispredict = resolve && (is_br ? ((pc_src != ex_pred_taken) ||
                                             (pc_src && ex_pred_taken &&
                                              (ex_target != ex_pred_target)))
                                          : ex_pred_taken);
    assign correct_pc = pc_src ? ex_target : (ex_pc + XLEN'(4));
    assign e_idx      = ex_pc[IDX_BITS+1:2];
    assign e_tag      = ex_pc[XLEN-1:IDX_BITS+2];
    assign e_hit      = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);

    // Control FSM, redirect register and performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            fcnt           <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            branch_cnt     <= '0;
            mispred_cnt    <= '0;
        end else begin
            redirect_valid <= 1'b0;
            case (state)
                RUN: begin
                    if (mispredict) begin
                        state          <= FLUSH;
                        flush          <= 1'b1;
                        fcnt           <= FCNT_LOAD;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= correct_pc;
                    end
                end
                FLUSH: begin
                    if (fcnt == '0) begin
                        state <= RUN;
                        flush <= 1'b0;
                    end else begin
                        fcnt <= fcnt - FCNT_W'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    flush <= 1'b0;
                end
            endcase
            if (resolve && is_br && (branch_cnt != '1))
                branch_cnt <= branch_cnt + CNT_W'(1);
            if (mispredict && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

    // BTB update for resolved branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= CTR_WNT;
            end
        end else if (resolve && is_br) begin
            if (e_hit) begin
                if (pc_src) begin
                    btb_target[e_idx] <= ex_target;
                    if (btb_ctr[e_idx] != '1)
                        btb_ctr[e_idx] <= btb_ctr[e_idx] + CTR_BITS'(1);
                end else if (btb_ctr[e_idx] != '0) begin
                    btb_ctr[e_idx] <= btb_ctr[e_idx] - CTR_BITS'(1);
                end
            end else if (pc_src) begin
                btb_valid[e_idx]  <= 1'b1;
                btb_tag[e_idx]    <= e_tag;
                btb_target[e_idx] <= ex_target;
                btb_ctr[e_idx]    <= CTR_WT;
            end
        end
    end

endmodule

// File: tb/tb_branch_pred_ctlr.sv
module tb_branch_pred_ctlr;
  localparam int XLEN = 32;
  localparam int IDX_BITS = 4;
  localparam int CTR_BITS = 2;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W = 32;
  localparam int NENT = 1 << IDX_BITS;
  localparam int CTR_MAX = (1 << CTR_BITS) - 1;
  localparam int CTR_HALF = 1 << (CTR_BITS - 1);
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  branch_in;
  logic        zero_flag;
  logic        sign_flag;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        pc_src;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  branch_pred_ctlr #(
    .XLEN(XLEN), .IDX_BITS(IDX_BITS), .CTR_BITS(CTR_BITS),
    .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .branch_in(branch_in),
    .zero_flag(zero_flag), .sign_flag(sign_flag), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc_src(pc_src), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_valid [NENT];
  int unsigned m_tag   [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_ctr   [NENT];
  int          m_rem;        // flush cycles still to come
  bit          m_rv;
  logic [31:0] m_rpc;
  longint      m_br;
  longint      m_mis;
  logic [31:0] exp_q[$];     // expected redirect targets, in order

  function automatic bit exp_taken(logic [2:0] b, logic zf, logic sf);
    case (b)
      3'd1: return zf;
      3'd2: return !zf;
      3'd3: return sf;
      3'd4: return !sf;
      3'd5, 3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return pc >> (IDX_BITS + 2);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i] = 0;
      m_tgt[i] = '0;
      m_ctr[i] = CTR_HALF - 1;
    end
    m_rem = 0;
    m_rv = 1'b0;
    m_rpc = '0;
    m_br = 0;
    m_mis = 0;
    exp_q.delete();
  endfunction

  function automatic void model_lookup(logic [31:0] pc, output bit pt, output logic [31:0] ptgt);
    int i;
    bit hit;
    i = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    pt = hit && (m_ctr[i] >= CTR_HALF);
    ptgt = hit ? m_tgt[i] : 32'h0;
  endfunction

  function automatic void model_resolve();
    bit br, tk, mis;
    int i;
    br = (branch_in >= 3'd1) && (branch_in <= 3'd6);
    tk = exp_taken(branch_in, zero_flag, sign_flag);
    if (br) mis = (tk != ex_pred_taken) || (tk && ex_pred_taken && ex_target != ex_pred_target);
    else    mis = ex_pred_taken;
    if (br) begin
      if (m_br < CNT_MAX) m_br++;
      i = idx_of(ex_pc);
      if (m_valid[i] && m_tag[i] == tag_of(ex_pc)) begin
        if (tk) begin
          m_tgt[i] = ex_target;
          if (m_ctr[i] < CTR_MAX) m_ctr[i]++;
        end else if (m_ctr[i] > 0) begin
          m_ctr[i]--;
        end
      end else if (tk) begin
        m_valid[i] = 1'b1;
        m_tag[i] = tag_of(ex_pc);
        m_tgt[i] = ex_target;
        m_ctr[i] = CTR_HALF;
      end
    end
    if (mis) begin
      if (m_mis < CNT_MAX) m_mis++;
      m_rem = FLUSH_CYCLES;
      m_rv = 1'b1;
      m_rpc = tk ? ex_target : 32'(ex_pc + 32'd4);
      exp_q.push_back(m_rpc);
    end
  endfunction

  // The model advances at every active edge. Inputs change 1 time unit later.
  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_rv = 1'b0;
      if (m_rem > 0) m_rem--;
      else if (ex_valid) model_resolve();
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin : compare
    bit pt;
    logic [31:0] ptgt;
    if (rst_n) begin
      model_lookup(fetch_pc, pt, ptgt);
      chk("pred_taken", 64'(pred_taken), 64'(pt));
      chk("pred_target", 64'(pred_target), 64'(ptgt));
      chk("pc_src", 64'(pc_src), 64'(exp_taken(branch_in, zero_flag, sign_flag)));
      chk("redirect_valid", 64'(redirect_valid), 64'(m_rv));
      if (m_rv) begin
        chk("redirect_pc", 64'(redirect_pc), 64'(exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF));
      end
      chk("flush", 64'(flush), 64'(m_rem > 0));
      chk("branch_cnt", 64'(branch_cnt), 64'(m_br));
      chk("mispred_cnt", 64'(mispred_cnt), 64'(m_mis));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(logic v, logic [2:0] b, logic zf, logic sf, logic [31:0] pc,
                          logic [31:0] tgt, logic pt, logic [31:0] ptgt);
    ex_valid = v;
    branch_in = b;
    zero_flag = zf;
    sign_flag = sf;
    ex_pc = pc;
    ex_target = tgt;
    ex_pred_taken = pt;
    ex_pred_target = ptgt;
  endtask

  task automatic idle();
    drive_ex(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(4, 7)) << (IDX_BITS + 2)) | (32'($urandom_range(0, NENT - 1)) << 2);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit pt;
    logic [31:0] ptgt;
    rst_n = 1'b0;
    model_reset();
    idle();
    fetch_pc = 32'h100;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset pred_taken", 64'(pred_taken), 64'd0);
    chk("reset branch_cnt", 64'(branch_cnt), 64'd0);
    chk("reset mispred_cnt", 64'(mispred_cnt), 64'd0);
    chk("reset flush", 64'(flush), 64'd0);
    chk("reset redirect_valid", 64'(redirect_valid), 64'd0);

    // BEQ taken, predicted not taken -> redirect to 0x200, allocate.
    drive_ex(1, 3'd1, 1, 0, 32'h100, 32'h200, 0, 32'h0);
    #1 chk("beq pc_src", 64'(pc_src), 64'd1);
    step();
    chk("beq redirect_valid", 64'(redirect_valid), 64'd1);
    chk("beq redirect_pc", 64'(redirect_pc), 64'h200);
    chk("beq flush", 64'(flush), 64'd1);
    chk("beq alloc pred_taken", 64'(pred_taken), 64'd1);
    chk("beq alloc pred_target", 64'(pred_target), 64'h200);
    // BNE in EX during the flush must be ignored.
    drive_ex(1, 3'd2, 0, 0, 32'h104, 32'h500, 0, 32'h0);
    step();
    chk("flush1 redirect_valid", 64'(redirect_valid), 64'd0);
    chk("flush1 flush", 64'(flush), 64'd1);
    chk("flush1 branch_cnt", 64'(branch_cnt), 64'd1);
    step();
    chk("flush2 flush", 64'(flush), 64'd0);
    chk("flush2 branch_cnt", 64'(branch_cnt), 64'd1);
    chk("flush2 mispred_cnt", 64'(mispred_cnt), 64'd1);
    chk("flush2 pred_taken", 64'(pred_taken), 64'd1);
    idle();

    // Same BEQ not taken, predicted taken -> redirect 0x104, counter to weakly not-taken.
    drive_ex(1, 3'd1, 0, 0, 32'h100, 32'h200, 1, 32'h200);
    step();
    idle();
    chk("nt1 redirect_pc", 64'(redirect_pc), 64'h104);
    chk("nt1 pred_taken", 64'(pred_taken), 64'd0);
    chk("nt1 pred_target", 64'(pred_target), 64'h200);
    step();
    step();
    // Not taken again, predicted correctly -> no redirect, counter to 0.
    drive_ex(1, 3'd1, 0, 0, 32'h100, 32'h200, 0, 32'h0);
    step();
    idle();
    chk("nt2 redirect_valid", 64'(redirect_valid), 64'd0);
    chk("nt2 branch_cnt", 64'(branch_cnt), 64'd3);
    chk("nt2 mispred_cnt", 64'(mispred_cnt), 64'd2);
    // Taken once from strongly not-taken: counter goes to 1, still not taken.
    drive_ex(1, 3'd1, 1, 0, 32'h100, 32'h200, 0, 32'h0);
    step();
    idle();
    chk("ctr0 pred_taken", 64'(pred_taken), 64'd0);
    step();
    step();

    // JAL: allocate with 0x300, then hit with a new target 0x340.
    drive_ex(1, 3'd6, 0, 0, 32'h108, 32'h300, 0, 32'h0);
    step();
    idle();
    step();
    step();
    fetch_pc = 32'h108;
    #1;
    chk("jal pred_taken", 64'(pred_taken), 64'd1);
    chk("jal pred_target", 64'(pred_target), 64'h300);
    drive_ex(1, 3'd6, 0, 0, 32'h108, 32'h340, 1, 32'h300);
    step();
    idle();
    chk("jal redirect_pc", 64'(redirect_pc), 64'h340);
    chk("jal new target", 64'(pred_target), 64'h340);
    chk("jal branch_cnt", 64'(branch_cnt), 64'd6);
    step();
    step();

    // Non-branch predicted taken at the top of memory -> redirect wraps to 0.
    drive_ex(1, 3'd0, 0, 0, 32'hFFFF_FFFC, 32'h0, 1, 32'h1234);
    #1 chk("nb pc_src", 64'(pc_src), 64'd0);
    step();
    idle();
    chk("nb redirect_valid", 64'(redirect_valid), 64'd1);
    chk("nb redirect_pc", 64'(redirect_pc), 64'h0);
    chk("nb mispred_cnt", 64'(mispred_cnt), 64'd6);
    chk("nb branch_cnt", 64'(branch_cnt), 64'd6);
    // Asynchronous reset in the middle of the flush.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("areset flush", 64'(flush), 64'd0);
    chk("areset redirect_valid", 64'(redirect_valid), 64'd0);
    chk("areset redirect_pc", 64'(redirect_pc), 64'd0);
    chk("areset mispred_cnt", 64'(mispred_cnt), 64'd0);
    chk("areset pred_taken", 64'(pred_taken), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post reset flush", 64'(flush), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      fetch_pc = rand_pc();
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_pc = ($urandom_range(0, 99) == 0) ? 32'hFFFF_FFFC : rand_pc();
      branch_in = 3'($urandom_range(0, 7));
      zero_flag = 1'($urandom_range(0, 1));
      sign_flag = 1'($urandom_range(0, 1));
      ex_target = 32'($urandom_range(0, 7)) << 4;
      if ($urandom_range(0, 9) < 7) begin
        model_lookup(ex_pc, pt, ptgt);
        ex_pred_taken = pt;
        ex_pred_target = ptgt;
      end else begin
        ex_pred_taken = 1'($urandom_range(0, 1));
        ex_pred_target = 32'($urandom_range(0, 7)) << 4;
      end
      step();
    end
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
